uart_rx_deframer: RTL

Serial-to-parallel UART receive stage that sits directly upstream of uart_requester.
- Samples the asynchronous rx line and recovers frames: 1 start bit, 5-8 data bits, optional even parity, 1 stop bit.
- Pushes each received character into a small first-word-fall-through FIFO.
- uart_requester drains the FIFO over a valid/ready handshake and forwards characters to Renode.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_deframer_if.sv | 24 ++
 rtl/uart_rx_fifo.sv | 62 ++++++
 rtl/uart_rx_deframer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
//   rx_state_t - receive FSM states
//   MinDiv     - smallest usable clock-cycles-per-bit divider
//   data_bits  - decode of the 2-bit data-width configuration field
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int unsigned MinDiv = 4;

    function automatic logic [3:0] data_bits(input logic [1:0] cfg_bits);
        return 4'd5 + {2'b00, cfg_bits};
    endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Character stream handshake between the deframer and its consumer.
//   rx_data_o  - head character, zero-extended to 8 bits
//   rx_valid_o - a character is available
//   rx_ready_i - consumer accepts the head when rx_valid_o is also high
// master: character source (deframer); slave: consumer.
interface uart_rx_deframer_if;

    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;

    modport master (
        output rx_data_o,
        output rx_valid_o,
        input  rx_ready_i
    );

    modport slave (
        input  rx_data_o,
        input  rx_valid_o,
        output rx_ready_i
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO for received characters.
//   clk, rst   - clock, synchronous active-high reset (empties the FIFO)
//   push       - write push_data this cycle
//   push_data  - character to store
//   pop        - consume the head (ignored when empty)
//   pop_data   - head character, 0 while empty
//   full/empty - occupancy status
//   overrun    - one-cycle pulse: push while full with no same-cycle pop
module uart_rx_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             overrun
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    // One extra pointer bit distinguishes full from empty.
    logic [PtrW:0]    wr_ptr;
    logic [PtrW:0]    rd_ptr;
    logic             pop_ok;
    logic             wr_en;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PtrW] != rd_ptr[PtrW]) &&
                      (wr_ptr[PtrW-1:0] == rd_ptr[PtrW-1:0]);
    assign pop_ok   = pop && !empty;
    // A pop frees the slot being written, so a full FIFO still accepts.
    assign wr_en    = push && (!full || pop_ok);
    assign overrun  = push && full && !pop_ok;
    assign pop_data = empty ? '0 : mem[rd_ptr[PtrW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + {{PtrW{1'b0}}, 1'b1};
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + {{PtrW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[PtrW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronizes rx_i, recovers 1 start, 5-8 data,
// optional even parity and 1 stop bit, and queues characters in a FWFT FIFO.
//   clk, rst         - clock, synchronous active-high reset
//   rx_i             - asynchronous serial input, idle high
//   cfg_en_i         - receiver enable (gates new start edges only)
//   cfg_div_i        - clock cycles per bit, clamped to at least MinDiv
//   cfg_parity_en_i  - even parity bit present
//   cfg_bits_i       - data bits = 5 + cfg_bits_i
//   rx_if            - character stream out (data/valid/ready)
//   busy_o           - receive FSM not idle
//   parity_err_o, frame_err_o, overrun_o - sticky error flags
//   err_clr_i        - clears the sticky flags (a same-cycle set wins)
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int unsigned FifoDepth = 4,
    parameter int unsigned DivWidth  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_i,
    input  logic                cfg_en_i,
    input  logic [DivWidth-1:0] cfg_div_i,
    input  logic                cfg_parity_en_i,
    input  logic [1:0]          cfg_bits_i,
    uart_rx_deframer_if.master  rx_if,
    output logic                busy_o,
    output logic                parity_err_o,
    output logic                frame_err_o,
    output logic                overrun_o,
    input  logic                err_clr_i
);

    logic                rx_meta;
    logic                rx_s;
    logic                rx_s_q;
    logic                start_edge;

    rx_state_t           state;
    logic [DivWidth-1:0] div_eff;
    logic [DivWidth-1:0] div_q;
    logic [DivWidth-1:0] cnt;
    logic                sample;
    logic [3:0]          nbits_q;
    logic                par_en_q;
    logic [2:0]          bit_idx;
    logic [7:0]          shreg;
    logic                par_acc;
    logic                par_bad;

    logic                push;
    logic                stop_bad;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_overrun;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
            rx_s_q  <= rx_s;
        end
    end

    // A line held low produces no further edge, so a break cannot retrigger.
    assign start_edge = rx_s_q && !rx_s;
    assign div_eff    = (cfg_div_i < DivWidth'(MinDiv)) ? DivWidth'(MinDiv) : cfg_div_i;
    assign sample     = (cnt == '0);
    assign busy_o     = (state != IDLE);
    assign push       = (state == STOP) && sample && rx_s;
    assign stop_bad   = (state == STOP) && sample && !rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            div_q        <= DivWidth'(MinDiv);
            cnt          <= '0;
            nbits_q      <= 4'd8;
            par_en_q     <= 1'b0;
            bit_idx      <= '0;
            shreg        <= '0;
            par_acc      <= 1'b0;
            par_bad      <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            if (state != IDLE) begin
                cnt <= sample ? (div_q - DivWidth'(1)) : (cnt - DivWidth'(1));
            end

            case (state)
                IDLE: begin
                    if (start_edge && cfg_en_i) begin
                        div_q    <= div_eff;
                        nbits_q  <= data_bits(cfg_bits_i);
                        par_en_q <= cfg_parity_en_i;
                        cnt      <= div_eff >> 1;
                        bit_idx  <= '0;
                        shreg    <= '0;
                        par_acc  <= 1'b0;
                        par_bad  <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (sample) begin
                        state <= rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (sample) begin
                        shreg[bit_idx] <= rx_s;
                        par_acc        <= par_acc ^ rx_s;
                        if ({1'b0, bit_idx} == nbits_q - 4'd1) begin
                            state <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (sample) begin
                        par_bad <= par_acc ^ rx_s;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (sample) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (push && par_bad) begin
                parity_err_o <= 1'b1;
            end else if (err_clr_i) begin
                parity_err_o <= 1'b0;
            end

            if (stop_bad) begin
                frame_err_o <= 1'b1;
            end else if (err_clr_i) begin
                frame_err_o <= 1'b0;
            end

            if (fifo_overrun) begin
                overrun_o <= 1'b1;
            end else if (err_clr_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

    assign pop              = rx_if.rx_valid_o && rx_if.rx_ready_i;
    assign rx_if.rx_valid_o = !fifo_empty;

    uart_rx_fifo #(
        .Depth (FifoDepth),
        .Width (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shreg),
        .pop       (pop),
        .pop_data  (rx_if.rx_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overrun   (fifo_overrun)
    );

endmodule
